// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweeper: drives every input vector of a small combinational
// unit in ascending order, lets it settle, and compares its output to a parameter table.
module truth_table_checker #(
  parameter int                  N_IN          = 3,
  parameter logic [2**N_IN-1:0]  EXPECT        = 8'h5B,
  parameter int                  SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop_on_err,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_idx
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]    ERR_ONE  = (N_IN+1)'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic            stopLatch, stopLatchNext;
  logic [N_IN-1:0] dutInNext;
  logic            busyNext, doneNext;
  logic [N_IN:0]   errNext;
  logic            firstValidNext;
  logic [N_IN-1:0] firstIdxNext;
  logic            mismatch;

  // Only meaningful in SAMPLE; dut_out is ignored while the unit settles.
  assign mismatch = (dut_out != EXPECT[dut_in]);
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      stopLatch       <= 1'b0;
      dut_in          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      state           <= stateNext;
      cnt             <= cntNext;
      stopLatch       <= stopLatchNext;
      dut_in          <= dutInNext;
      busy            <= busyNext;
      done            <= doneNext;
      err_count       <= errNext;
      first_err_valid <= firstValidNext;
      first_err_idx   <= firstIdxNext;
    end
  end

  always_comb begin
    stateNext      = state;
    cntNext        = cnt;
    stopLatchNext  = stopLatch;
    dutInNext      = dut_in;
    busyNext       = busy;
    doneNext       = done;
    errNext        = err_count;
    firstValidNext = first_err_valid;
    firstIdxNext   = first_err_idx;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          stopLatchNext  = stop_on_err;
          errNext        = '0;
          firstValidNext = 1'b0;
          firstIdxNext   = '0;
          doneNext       = 1'b0;
          dutInNext      = '0;
          busyNext       = 1'b1;
          cntNext        = '0;
          stateNext      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          stateNext = SAMPLE;
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          errNext = err_count + ERR_ONE;
          if (!first_err_valid) begin
            firstValidNext = 1'b1;
            firstIdxNext   = dut_in;
          end
        end
        // The sweep ends on the all-ones vector, so dut_in never wraps.
        if ((dut_in == '1) || (mismatch && stopLatch)) begin
          stateNext = DONE;
          busyNext  = 1'b0;
          doneNext  = 1'b1;
        end else begin
          dutInNext = dut_in + VEC_ONE;
          cntNext   = '0;
          stateNext = SETTLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
